// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer.
// State encoding, HI/LO regfile indices and divider iteration count.
package md_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } md_state_e;

  localparam logic [5:0] REG_HI = 6'b100001;
  localparam logic [5:0] REG_LO = 6'b100000;
  localparam int unsigned DIV_CYCLES = 32;

endpackage

// File: rtl/md_divider.sv
// Iterative restoring divider core, one quotient bit per cycle.
// Ports: clk, reset, start_i, dividend_i, divisor_i (unsigned magnitudes),
// done_o (high on final iteration), quotient_o, remainder_o (final step value).
module md_divider
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  logic        busy_q;
  logic [4:0]  cnt_q;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        last;

  // Remainder stays below the divisor, so bit 32 of the
  // difference is a clean borrow flag.
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, dvs_q};
    if (!diff[32]) begin
      rem_d = diff[31:0];
      quo_d = {quo_q[30:0], 1'b1};
    end else begin
      rem_d = shifted[31:0];
      quo_d = {quo_q[30:0], 1'b0};
    end
  end

  assign last = (cnt_q == 5'(DIV_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= dividend_i;
      dvs_q  <= divisor_i;
    end else if (busy_q) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_q + 5'd1;
      if (last) busy_q <= 1'b0;
    end
  end

  // Result is presented on the same cycle the last bit is formed.
  assign done_o      = busy_q & last;
  assign quotient_o  = quo_d;
  assign remainder_o = rem_d;

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide sequencer: fixed-latency multiply, 32-step divide, HI/LO write.
// Ports: clk, reset, md_* request from decode, hilo_access; md_busy, md_stall,
// hi_we/lo_we strobes and hi_wdata/lo_wdata results.
module md_ctrl
  import md_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_mult_en,
  input  logic        md_div_en,
  input  logic        md_is_signed,
  input  logic [31:0] md_src1,
  input  logic [31:0] md_src2,
  input  logic        hilo_access,
  output logic        md_busy,
  output logic        md_stall,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata
);

  md_state_e   state_q, state_d;
  logic [7:0]  cnt_q;
  logic [31:0] a_q, b_q;
  logic        sgn_q;
  logic [31:0] hi_q, lo_q;
  logic        accept;
  logic        div_start;
  logic        mul_last;
  logic [31:0] dvd_mag, dvs_mag;
  logic        div_done;
  logic [31:0] quo, rem;
  logic [31:0] q_fix, r_fix;
  logic [63:0] a_ext, b_ext, prod;

  assign accept    = (state_q == S_IDLE) & (md_mult_en | md_div_en);
  assign div_start = (state_q == S_IDLE) & md_div_en & ~md_mult_en;
  assign mul_last  = (cnt_q == 8'(MUL_LAT - 1));

  assign dvd_mag = (md_is_signed & md_src1[31]) ? (~md_src1 + 32'd1) : md_src1;
  assign dvs_mag = (md_is_signed & md_src2[31]) ? (~md_src2 + 32'd1) : md_src2;

  md_divider u_div (
    .clk         (clk),
    .reset       (reset),
    .start_i     (div_start),
    .dividend_i  (dvd_mag),
    .divisor_i   (dvs_mag),
    .done_o      (div_done),
    .quotient_o  (quo),
    .remainder_o (rem)
  );

  // Sign extension only when signed; low 64 bits of the product
  // are then correct for both flavours.
  assign a_ext = {{32{sgn_q & a_q[31]}}, a_q};
  assign b_ext = {{32{sgn_q & b_q[31]}}, b_q};
  assign prod  = a_ext * b_ext;

  assign q_fix = (sgn_q & (a_q[31] ^ b_q[31])) ? (~quo + 32'd1) : quo;
  assign r_fix = (sgn_q & a_q[31]) ? (~rem + 32'd1) : rem;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (md_mult_en)     state_d = S_MUL;
        else if (md_div_en) state_d = S_DIV;
      end
      S_MUL:  if (mul_last) state_d = S_DONE;
      S_DIV:  if (div_done) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    md_busy  = (state_q != S_IDLE);
    hi_we    = (state_q == S_DONE);
    lo_we    = (state_q == S_DONE);
    md_stall = md_busy & (md_mult_en | md_div_en | hilo_access);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sgn_q <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      if (accept) begin
        a_q   <= md_src1;
        b_q   <= md_src2;
        sgn_q <= md_is_signed;
        cnt_q <= '0;
      end
      if (state_q == S_MUL) begin
        cnt_q <= cnt_q + 8'd1;
        if (mul_last) begin
          hi_q <= prod[63:32];
          lo_q <= prod[31:0];
        end
      end
      if ((state_q == S_DIV) && div_done) begin
        // Zero divisor reports the raw dividend, no sign fix-up.
        if (b_q == 32'd0) begin
          hi_q <= a_q;
          lo_q <= 32'hFFFF_FFFF;
        end else begin
          hi_q <= r_fix;
          lo_q <= q_fix;
        end
      end
    end
  end

  assign hi_wdata = hi_q;
  assign lo_wdata = lo_q;

endmodule
